// File: rtl/control_if.sv
// control_if: handshake inputs and datapath control outputs of the multicycle control FSM.
interface control_if;
   logic       run;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, ALUSrcA, RegWrite, RegDst;
   logic [1:0] PCSource, ALUSrcB;
   logic [2:0] Entre_ALUC;
   logic       illegal;
   logic [3:0] estado;
   modport master (
      input  run, opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
             IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
             Entre_ALUC, illegal, estado
   );
   modport slave (
      output run, opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
             IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
             Entre_ALUC, illegal, estado
   );
endinterface

// File: rtl/control_multiciclo.sv
// control_multiciclo: multicycle MIPS-subset main control FSM with mem_ready stalls.
// Define CONTROL_JUMP_EN to enable the J instruction (JUMP state); otherwise opcode 000010 is illegal.
module control_multiciclo (
   input logic     clk,
   input logic     rst_n,
   control_if.master b
);
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11,
      JUMP      = 4'd12
   } state_t;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   state_t state, nxt, bound;
   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : nxt;
   assign bound    = b.run ? FETCH : IDLE;
   assign b.estado = state;
   always_comb begin
      nxt           = state;
      b.PCWrite     = 1'b0;
      b.PCWriteCond = 1'b0;
      b.IorD        = 1'b0;
      b.MemRead     = 1'b0;
      b.MemWrite    = 1'b0;
      b.MemtoReg    = 1'b0;
      b.IRWrite     = 1'b0;
      b.ALUSrcA     = 1'b0;
      b.RegWrite    = 1'b0;
      b.RegDst      = 1'b0;
      b.PCSource    = 2'b00;
      b.ALUSrcB     = 2'b00;
      b.Entre_ALUC  = 3'b000;
      b.illegal     = 1'b0;
      case (state)
         IDLE: nxt = b.run ? FETCH : IDLE;
         FETCH: begin
            b.MemRead    = 1'b1;
            b.ALUSrcB    = 2'b01;
            b.Entre_ALUC = 3'b010;
            b.IRWrite    = b.mem_ready;
            b.PCWrite    = b.mem_ready;
            nxt          = b.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            // branch target is precomputed into ALUOut while the opcode is decoded
            b.ALUSrcB    = 2'b11;
            b.Entre_ALUC = 3'b010;
            case (b.opcode)
               OP_LW, OP_SW: nxt = MEM_ADDR;
               OP_R:         nxt = R_EXEC;
               OP_BEQ:       nxt = BRANCH;
               OP_ADDI:      nxt = ADDI_EXEC;
`ifdef CONTROL_JUMP_EN
               OP_J:         nxt = JUMP;
`else
               OP_J: begin
                  b.illegal = 1'b1;
                  nxt       = bound;
               end
`endif
               default: begin
                  b.illegal = 1'b1;
                  nxt       = bound;
               end
            endcase
         end
         MEM_ADDR: begin
            b.ALUSrcA    = 1'b1;
            b.ALUSrcB    = 2'b10;
            b.Entre_ALUC = 3'b010;
            nxt          = (b.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            b.MemRead = 1'b1;
            b.IorD    = 1'b1;
            nxt       = b.mem_ready ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            b.RegWrite = 1'b1;
            b.MemtoReg = 1'b1;
            nxt        = bound;
         end
         MEM_WRITE: begin
            b.MemWrite = 1'b1;
            b.IorD     = 1'b1;
            nxt        = b.mem_ready ? bound : MEM_WRITE;
         end
         R_EXEC: begin
            b.ALUSrcA = 1'b1;
            nxt       = R_WB;
         end
         R_WB: begin
            b.RegWrite = 1'b1;
            b.RegDst   = 1'b1;
            nxt        = bound;
         end
         BRANCH: begin
            b.ALUSrcA     = 1'b1;
            b.Entre_ALUC  = 3'b011;
            b.PCWriteCond = 1'b1;
            b.PCSource    = 2'b01;
            nxt           = bound;
         end
         ADDI_EXEC: begin
            b.ALUSrcA    = 1'b1;
            b.ALUSrcB    = 2'b10;
            b.Entre_ALUC = 3'b001;
            nxt          = ADDI_WB;
         end
         ADDI_WB: begin
            b.RegWrite   = 1'b1;
            b.Entre_ALUC = 3'b001;
            nxt          = bound;
         end
`ifdef CONTROL_JUMP_EN
         JUMP: begin
            b.PCWrite  = 1'b1;
            b.PCSource = 2'b10;
            nxt        = bound;
         end
`endif
         default: nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: directed per-cycle vector table plus hand sequences for jump and reset mid-stall.
module tb_control_multiciclo;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   control_if bus ();
   control_multiciclo dut (.clk(clk), .rst_n(rst_n), .b(bus.master));
   always #5 clk = ~clk;

   // packed outputs: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,Entre_ALUC,illegal
   localparam logic [17:0] O_IDLE = 18'd0;
   localparam logic [17:0] O_F1   = {10'b1001001000, 2'b00, 2'b01, 3'b010, 1'b0};
   localparam logic [17:0] O_F0   = {10'b0001000000, 2'b00, 2'b01, 3'b010, 1'b0};
   localparam logic [17:0] O_DEC  = {10'b0000000000, 2'b00, 2'b11, 3'b010, 1'b0};
   localparam logic [17:0] O_ILL  = {10'b0000000000, 2'b00, 2'b11, 3'b010, 1'b1};
   localparam logic [17:0] O_MAD  = {10'b0000000100, 2'b00, 2'b10, 3'b010, 1'b0};
   localparam logic [17:0] O_MRD  = {10'b0011000000, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [17:0] O_MWB  = {10'b0000010010, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [17:0] O_MWR  = {10'b0010100000, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [17:0] O_REX  = {10'b0000000100, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [17:0] O_RWB  = {10'b0000000011, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [17:0] O_BR   = {10'b0100000100, 2'b01, 2'b00, 3'b011, 1'b0};
   localparam logic [17:0] O_AEX  = {10'b0000000100, 2'b00, 2'b10, 3'b001, 1'b0};
   localparam logic [17:0] O_AWB  = {10'b0000000010, 2'b00, 2'b00, 3'b001, 1'b0};
   localparam logic [17:0] O_JMP  = {10'b1000000000, 2'b10, 2'b00, 3'b000, 1'b0};

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

   typedef struct {
      logic       run;
      logic [5:0] op;
      logic       mr;
      logic [3:0] s;
      logic [17:0] o;
   } vec_t;
   vec_t tv [32];

   function automatic vec_t v(logic run, logic [5:0] op, logic mr, logic [3:0] s, logic [17:0] o);
      vec_t x;
      x.run = run; x.op = op; x.mr = mr; x.s = s; x.o = o;
      return x;
   endfunction

   function automatic logic [17:0] outs();
      return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
              bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.PCSource, bus.ALUSrcB,
              bus.Entre_ALUC, bus.illegal};
   endfunction

   // inputs change at the falling edge; checks land 1 ns later, before the next rising edge
   task automatic step(input string name, input logic rn, input logic run, input logic [5:0] op,
                       input logic mr, input logic [3:0] s, input logic [17:0] o);
      @(negedge clk);
      rst_n = rn; bus.run = run; bus.opcode = op; bus.mem_ready = mr;
      #1;
      checks++;
      if (bus.estado !== s) begin
         errors++;
         $display("FAIL %s estado got %0d want %0d", name, bus.estado, s);
      end
      checks++;
      if (outs() !== o) begin
         errors++;
         $display("FAIL %s outputs got %b want %b", name, outs(), o);
      end
   endtask

   initial begin
      rst_n = 1'b0; bus.run = 1'b0; bus.opcode = R; bus.mem_ready = 1'b0;
      @(negedge clk);
      step("reset", 1'b0, 1'b1, R, 1'b1, 4'd0, O_IDLE);
      tv[0]  = v(0, R,    1, 4'd0,  O_IDLE);
      tv[1]  = v(1, R,    1, 4'd0,  O_IDLE);
      tv[2]  = v(1, R,    1, 4'd1,  O_F1);
      tv[3]  = v(1, R,    0, 4'd2,  O_DEC);
      tv[4]  = v(0, R,    0, 4'd7,  O_REX);
      tv[5]  = v(1, R,    0, 4'd8,  O_RWB);
      tv[6]  = v(1, LW,   0, 4'd1,  O_F0);
      tv[7]  = v(1, LW,   1, 4'd1,  O_F1);
      tv[8]  = v(1, LW,   1, 4'd2,  O_DEC);
      tv[9]  = v(1, LW,   1, 4'd3,  O_MAD);
      tv[10] = v(1, LW,   0, 4'd4,  O_MRD);
      tv[11] = v(1, LW,   0, 4'd4,  O_MRD);
      tv[12] = v(1, LW,   1, 4'd4,  O_MRD);
      tv[13] = v(1, LW,   0, 4'd5,  O_MWB);
      tv[14] = v(1, SW,   1, 4'd1,  O_F1);
      tv[15] = v(1, SW,   1, 4'd2,  O_DEC);
      tv[16] = v(1, SW,   1, 4'd3,  O_MAD);
      tv[17] = v(0, SW,   0, 4'd6,  O_MWR);
      tv[18] = v(1, SW,   1, 4'd6,  O_MWR);
      tv[19] = v(1, BEQ,  1, 4'd1,  O_F1);
      tv[20] = v(1, BEQ,  1, 4'd2,  O_DEC);
      tv[21] = v(1, BEQ,  0, 4'd9,  O_BR);
      tv[22] = v(1, ADDI, 1, 4'd1,  O_F1);
      tv[23] = v(1, ADDI, 1, 4'd2,  O_DEC);
      tv[24] = v(0, ADDI, 1, 4'd10, O_AEX);
      tv[25] = v(0, ADDI, 1, 4'd11, O_AWB);
      tv[26] = v(0, ADDI, 1, 4'd0,  O_IDLE);
      tv[27] = v(1, BAD,  1, 4'd0,  O_IDLE);
      tv[28] = v(1, BAD,  1, 4'd1,  O_F1);
      tv[29] = v(1, BAD,  1, 4'd2,  O_ILL);
      tv[30] = v(1, BAD,  0, 4'd1,  O_F0);
      tv[31] = v(1, J,    1, 4'd1,  O_F1);
      for (int i = 0; i < 32; i++)
         step($sformatf("row%0d", i), 1'b1, tv[i].run, tv[i].op, tv[i].mr, tv[i].s, tv[i].o);
`ifdef CONTROL_JUMP_EN
      step("j_decode", 1'b1, 1'b1, J, 1'b1, 4'd2,  O_DEC);
      step("j_jump",   1'b1, 1'b1, J, 1'b1, 4'd12, O_JMP);
`else
      step("j_illegal", 1'b1, 1'b1, J, 1'b1, 4'd2, O_ILL);
`endif
      step("j_refetch",   1'b1, 1'b1, LW, 1'b1, 4'd1, O_F1);
      step("rs_decode",   1'b1, 1'b1, LW, 1'b1, 4'd2, O_DEC);
      step("rs_addr",     1'b1, 1'b1, LW, 1'b0, 4'd3, O_MAD);
      step("rs_stall",    1'b1, 1'b1, LW, 1'b0, 4'd4, O_MRD);
      step("rs_assert",   1'b0, 1'b1, LW, 1'b0, 4'd4, O_MRD);
      step("rs_idle",     1'b1, 1'b0, LW, 1'b1, 4'd0, O_IDLE);
      step("rs_hold",     1'b1, 1'b0, LW, 1'b1, 4'd0, O_IDLE);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
